// File: rtl/unstriping_if.sv
// Lane-side and stream-side signals of the un-striping block.
// The DUT uses the slave modport; upstream/test drivers use the master modport.
interface unstriping_if #(
    parameter int DW = 8
);
    logic [DW-1:0] FL0;
    logic [DW-1:0] FL1;
    logic [DW-1:0] FL2;
    logic [DW-1:0] FL3;
    logic          valid_in;
    logic [1:0]    width;
    logic [DW-1:0] toDemux;
    logic          valid_out;

    modport master (
        output FL0, FL1, FL2, FL3, valid_in, width,
        input  toDemux, valid_out
    );

    modport slave (
        input  FL0, FL1, FL2, FL3, valid_in, width,
        output toDemux, valid_out
    );
endinterface

// File: rtl/unstriping.sv
// Byte un-striping: captures up to four lane bytes in one clock, then
// emits them in lane order (lane 0 first) on a single registered byte stream.
module unstriping #(
    parameter int            DW        = 8,
    parameter logic [DW-1:0] IDLE_BYTE = 8'h00
) (
    input logic          clk,
    input logic          reset_L,
    unstriping_if.slave  lanes
);
    logic [1:0]      ptr_reg;
    logic [2:0]      n_reg;
    logic [DW-1:0]   to_demux_reg;
    logic            valid_out_reg;
    logic [2:0]      n_next;
    logic [2:0]      ptr_inc;
    logic            capture;
    logic [DW-1:0]   sh_sel;
    logic [3*DW-1:0] sh_flat;
    logic [DW-1:0]   lane_in [0:3];

    assign lane_in[0] = lanes.FL0;
    assign lane_in[1] = lanes.FL1;
    assign lane_in[2] = lanes.FL2;
    assign lane_in[3] = lanes.FL3;

    // A new group is only accepted when the previous one has fully drained.
    assign capture = (ptr_reg == 2'd0) && lanes.valid_in;
    assign ptr_inc = {1'b0, ptr_reg} + 3'd1;

    always_comb begin
        n_next = 3'd4;
        case (lanes.width)
            2'b00:   n_next = 3'd1;
            2'b01:   n_next = 3'd2;
            default: n_next = 3'd4;
        endcase
    end

    genvar gi;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_shadow
            logic [DW-1:0] sh_reg;
            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    sh_reg <= '0;
                end else if (capture) begin
                    sh_reg <= lane_in[gi];
                end
            end
            assign sh_flat[(gi-1)*DW +: DW] = sh_reg;
        end
    endgenerate

    always_comb begin
        sh_sel = sh_flat[DW-1:0];
        case (ptr_reg)
            2'd2:    sh_sel = sh_flat[2*DW-1:DW];
            2'd3:    sh_sel = sh_flat[3*DW-1:2*DW];
            default: sh_sel = sh_flat[DW-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            to_demux_reg  <= IDLE_BYTE;
            valid_out_reg <= 1'b0;
            ptr_reg       <= 2'd0;
            n_reg         <= 3'd4;
        end else if (ptr_reg == 2'd0) begin
            if (lanes.valid_in) begin
                to_demux_reg  <= lane_in[0];
                valid_out_reg <= 1'b1;
                n_reg         <= n_next;
                ptr_reg       <= (n_next == 3'd1) ? 2'd0 : 2'd1;
            end else begin
                to_demux_reg  <= IDLE_BYTE;
                valid_out_reg <= 1'b0;
            end
        end else begin
            // Mid-group: lane inputs, valid_in and width are deliberately ignored.
            to_demux_reg  <= sh_sel;
            valid_out_reg <= 1'b1;
            ptr_reg       <= (ptr_inc == n_reg) ? 2'd0 : ptr_inc[1:0];
        end
    end

    assign lanes.toDemux   = to_demux_reg;
    assign lanes.valid_out = valid_out_reg;
endmodule

// File: tb/tb_unstriping.sv
// Scoreboard bench for unstriping: stimulus pushes expected bytes, a negedge
// monitor pops and compares every valid output byte.
module tb_unstriping;
    logic clk;
    logic reset_L;
    int   checks;
    int   failures;
    int   run_len;
    int   max_run;
    logic [7:0] exp_q[$];

    unstriping_if #(.DW(8)) bus ();

    unstriping #(.DW(8), .IDLE_BYTE(8'h00)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .lanes   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every valid byte must match the head of the queue; idle cycles carry IDLE_BYTE.
    always @(negedge clk) begin
        if (bus.valid_out === 1'b1) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_byte: got %0h expected none", bus.toDemux);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("stream_byte", {24'h0, bus.toDemux}, {24'h0, e});
                $display("byte %02h (expected %02h)", bus.toDemux, e);
            end
        end else begin
            run_len = 0;
            check("idle_byte", {24'h0, bus.toDemux}, 32'h0);
        end
    end

    task automatic idle(input int cycles);
        bus.valid_in = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one group at the next edge; mid-group cycles drive junk that must be ignored.
    task automatic send(input logic [1:0] w, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
        int n;
        n = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
        bus.width = w; bus.valid_in = 1'b1;
        bus.FL0 = b0; bus.FL1 = b1; bus.FL2 = b2; bus.FL3 = b3;
        exp_q.push_back(b0);
        if (n > 1) exp_q.push_back(b1);
        if (n > 2) begin
            exp_q.push_back(b2);
            exp_q.push_back(b3);
        end
        @(posedge clk);
        for (int i = 1; i < n; i++) begin
            #1;
            bus.FL0 = 8'h99; bus.FL1 = 8'h99; bus.FL2 = 8'h99; bus.FL3 = 8'h99;
            bus.valid_in = 1'b1; bus.width = 2'b10;
            @(posedge clk);
        end
        #1;
        bus.valid_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; run_len = 0; max_run = 0;
        reset_L = 1'b0;
        bus.FL0 = 8'hA5; bus.FL1 = 8'h5A; bus.FL2 = 8'h3C; bus.FL3 = 8'hC3;
        bus.valid_in = 1'b1; bus.width = 2'b10;
        repeat (3) @(posedge clk);
        #1;
        check("reset_toDemux", {24'h0, bus.toDemux}, 32'h0);
        check("reset_valid", {31'h0, bus.valid_out}, 32'h0);
        bus.valid_in = 1'b0;
        reset_L = 1'b1;
        idle(3);
        check("post_reset_valid", {31'h0, bus.valid_out}, 32'h0);

        // Single x4 group then idle
        send(2'b10, 8'hFB, 8'hFF, 8'hFF, 8'hFD);
        idle(4);

        // Back-to-back x4 groups must form one 8-byte run
        max_run = 0;
        send(2'b10, 8'hBC, 8'h1C, 8'h1C, 8'h1C);
        send(2'b10, 8'hFB, 8'h01, 8'h02, 8'hFD);
        idle(4);
        check("b2b_run_len", max_run, 32'd8);

        // x2 group; width forced to x4 mid-group by send() must not matter
        send(2'b01, 8'h5C, 8'hAA, 8'hEE, 8'hEE);
        send(2'b10, 8'h10, 8'h20, 8'h30, 8'h40);
        idle(3);

        // x1 pass-through
        send(2'b00, 8'h11, 8'hEE, 8'hEE, 8'hEE);
        send(2'b00, 8'h22, 8'hEE, 8'hEE, 8'hEE);
        send(2'b00, 8'h33, 8'hEE, 8'hEE, 8'hEE);
        idle(3);
        check("queue_drained_1", exp_q.size(), 32'd0);

        // Reset mid-group after the second output byte
        bus.width = 2'b10; bus.valid_in = 1'b1;
        bus.FL0 = 8'hFB; bus.FL1 = 8'hFF; bus.FL2 = 8'hFF; bus.FL3 = 8'hFD;
        exp_q.push_back(8'hFB);
        exp_q.push_back(8'hFF);
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        @(posedge clk);
        #7;
        reset_L = 1'b0;
        #1;
        check("midreset_toDemux", {24'h0, bus.toDemux}, 32'h0);
        check("midreset_valid", {31'h0, bus.valid_out}, 32'h0);
        check("midreset_consumed", exp_q.size(), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midreset_hold_valid", {31'h0, bus.valid_out}, 32'h0);
        reset_L = 1'b1;
        send(2'b10, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
        idle(4);
        check("queue_drained_2", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/unstriping.md
Name: unstriping

Overview:
- PCIe-style byte un-striping block for the receive path of a multi-lane link.
- Collects one byte per active lane (FL0..FL3) in a single clock, then serializes them in lane order (lane 0 first) onto a single byte stream, toDemux.
- toDemux feeds the downstream demultiplexer / packet parser.
- Supports x1, x2 and x4 link widths, selected at group boundaries.

Parameters:
- DW, 8, byte width of each lane and of toDemux.
- IDLE_BYTE, 8'h00, value driven on toDemux when no byte is valid.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- FL0  input  DW  lane 0 byte (first byte of a group).
- FL1  input  DW  lane 1 byte.
- FL2  input  DW  lane 2 byte.
- FL3  input  DW  lane 3 byte.
- valid_in  input  1  lane bytes valid; sampled only at a group start.
- width  input  2  link width: 00=x1, 01=x2, 10=x4, 11=x4 (reserved, treated as x4).
- toDemux  output  DW  serialized byte stream, registered.
- valid_out  output  1  toDemux carries a valid byte, registered.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - toDemux=IDLE_BYTE, valid_out=0.
  - Lane pointer ptr=0, latched width N=4.
  - Shadow registers sh1..sh3 = 0.
  - Outputs stay at these values while reset_L is low.
  - First active edge after release behaves as a group start.
- Active lane count N: x1 → 1, x2 → 2, x4/reserved → 4.
  - width is sampled only when ptr==0; changes mid-group are ignored until the group ends.
- Group start (rising edge with ptr==0):
  - If valid_in=1:
    - toDemux<=FL0, valid_out<=1.
    - sh1<=FL1, sh2<=FL2, sh3<=FL3; shadows of inactive lanes are don't-care.
    - Latch N from width.
    - ptr<=1 if N>1, else ptr stays 0.
  - If valid_in=0: toDemux<=IDLE_BYTE, valid_out<=0, ptr stays 0.
- Mid-group (rising edge with ptr=i, 0<i<N):
  - toDemux<=sh_i, valid_out<=1.
  - ptr<=i+1, wrapping to 0 when i+1==N.
  - FL0..FL3, valid_in and width are ignored on these edges.
- Latency and throughput:
  - Byte k of a group appears on toDemux k+1 edges after the capture edge's input setup; lane 0 appears one cycle after capture.
  - A group occupies exactly N cycles.
  - Back-to-back groups give continuous valid_out=1 with no bubbles; the next capture occurs on the edge where ptr==0.
- Input timing: upstream must hold the lane bytes stable only for the capture edge. The block performs no framing or symbol decoding; bytes (STP, SDP, END, PAD, etc.) pass through unchanged.
- x1 mode: every edge with valid_in=1 passes FL0 straight through (registered); FL1..FL3 are unused.
- Reset asserted mid-group: the partial group is discarded; outputs go to their reset values immediately.

Test Plan:
- Reset: hold reset_L=0 with arbitrary lane inputs → toDemux=00, valid_out=0. Release and drive valid_in=0 → outputs remain 00/0.
- x4 group: width=10, valid_in=1, FL0=FB, FL1=FF, FL2=FF, FL3=FD for one edge → over the next 4 cycles toDemux = FB, FF, FF, FD with valid_out=1; afterwards with valid_in=0 → 00, valid_out=0.
- x4 back-to-back: group A (BC,1C,1C,1C), then group B (FB,01,02,FD) presented at the next ptr==0 edge → 8 contiguous valid bytes in order with no gap.
- x2 mode: width=01, FL0=5C, FL1=AA (FL2/FL3=EE, ignored) → toDemux 5C then AA, then next group capture. Changing width to 10 on the second cycle takes effect only at the next group start.
- x1 mode: width=00, FL0 sequence 11, 22, 33 with valid_in=1 → toDemux 11, 22, 33 one cycle delayed, valid_out=1 each cycle.
- Reset mid-group: start an x4 group (FB,FF,FF,FD) and assert reset_L=0 after the second output byte → toDemux=00 and valid_out=0 immediately. After release, a new group starts with FL0.
